// File: rtl/basic_io_pkg.sv
// Shared types and constants for the Nexys Video basic I/O path.
//   mode_e       : LED controller mode (MIRROR / COUNT / SHIFT)
//   BTN_*        : bit positions of each push button in the button vector
//   NUM_*        : pin counts for buttons, switches and LEDs
package basic_io_pkg;

  localparam int unsigned NUM_BUTTONS  = 6;
  localparam int unsigned NUM_SWITCHES = 8;
  localparam int unsigned NUM_LEDS     = 8;

  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_U   = 1;
  localparam int unsigned BTN_D   = 2;
  localparam int unsigned BTN_L   = 3;
  localparam int unsigned BTN_R   = 4;
  localparam int unsigned BTN_CLR = 5;

  typedef enum logic [1:0] {
    MIRROR = 2'd0,
    COUNT  = 2'd1,
    SHIFT  = 2'd2
  } mode_e;

endpackage

// File: rtl/basic_io_led_ctrl_if.sv
// Board pin bundle for the basic I/O path.
//   i_buttons  : raw push buttons (board -> controller)
//   i_switches : raw slide switches (board -> controller)
//   o_leds     : registered LED drive (controller -> board)
//   o_mode     : current controller mode (controller -> board)
// master = board / stimulus side, slave = LED controller.
interface basic_io_led_ctrl_if import basic_io_pkg::*; ();

  logic [NUM_BUTTONS-1:0]  i_buttons;
  logic [NUM_SWITCHES-1:0] i_switches;
  logic [NUM_LEDS-1:0]     o_leds;
  logic [1:0]              o_mode;

  modport master (
    output i_buttons,
    output i_switches,
    input  o_leds,
    input  o_mode
  );

  modport slave (
    input  i_buttons,
    input  i_switches,
    output o_leds,
    output o_mode
  );

endinterface

// File: rtl/basic_io_debounce.sv
// Synchronizer plus per-bit debouncer for a vector of raw inputs.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_raw        : asynchronous raw inputs
//   o_db         : debounced value, changes only after DEBOUNCE_CYCLES
//                  consecutive differing synchronized samples
module basic_io_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  db_q, db_d;

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  // Shift chain plus per-bit stability counters
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    cnt_d  = cnt_q;
    db_d   = db_q;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (sync_q[SYNC_STAGES-1][b] == db_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        db_d[b]  = sync_q[SYNC_STAGES-1][b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  assign o_db = db_q;

endmodule

// File: rtl/basic_io_led_ctrl.sv
// Nexys Video basic I/O LED controller.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io (slave)   : i_buttons[5:0] {clr,right,left,down,up,centre},
//                  i_switches[7:0], o_leds[7:0] (registered), o_mode[1:0]
// Buttons and switches are debounced; button press pulses drive a
// MIRROR/COUNT/SHIFT mode machine that selects what the LEDs display.
module basic_io_led_ctrl import basic_io_pkg::*; #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  basic_io_led_ctrl_if.slave  io
);

  logic [NUM_BUTTONS-1:0]  btn_db;
  logic [NUM_BUTTONS-1:0]  btn_prev_q, btn_prev_d;
  logic [NUM_BUTTONS-1:0]  press_c;
  logic [NUM_SWITCHES-1:0] sw_db;
  mode_e                   mode_q, mode_d;
  logic [NUM_LEDS-1:0]     count_q, count_d;
  logic [NUM_LEDS-1:0]     rot_q, rot_d;
  logic [NUM_LEDS-1:0]     leds_q, leds_d;

  basic_io_debounce #(
    .WIDTH           (NUM_BUTTONS),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_raw (io.i_buttons),
    .o_db  (btn_db)
  );

  basic_io_debounce #(
    .WIDTH           (NUM_SWITCHES),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_raw (io.i_switches),
    .o_db  (sw_db)
  );

  // Single-cycle pulse on a debounced 0->1 button transition
  assign btn_prev_d = btn_db;
  assign press_c    = btn_db & ~btn_prev_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q     <= MIRROR;
      btn_prev_q <= '0;
      count_q    <= '0;
      rot_q      <= '0;
      leds_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      btn_prev_q <= btn_prev_d;
      count_q    <= count_d;
      rot_q      <= rot_d;
      leds_q     <= leds_d;
    end
  end

  // Next mode: centre advances unless clear is pressed in the same cycle
  always_comb begin
    mode_d = mode_q;
    if (!press_c[BTN_CLR] && press_c[BTN_C]) begin
      case (mode_q)
        MIRROR:  mode_d = COUNT;
        COUNT:   mode_d = SHIFT;
        SHIFT:   mode_d = MIRROR;
        default: mode_d = MIRROR;
      endcase
    end
  end

  // Datapath updates and LED select, both from next-state values
  always_comb begin
    count_d = count_q;
    rot_d   = rot_q;
    leds_d  = '0;

    if (press_c[BTN_CLR]) begin
      count_d = '0;
      rot_d   = '0;
    end else if (press_c[BTN_C]) begin
      // Only COUNT->SHIFT lands in SHIFT, so this is exactly the entry case
      if (mode_d == SHIFT) rot_d = sw_db;
    end else begin
      case (mode_q)
        COUNT: begin
          if (press_c[BTN_U] && !press_c[BTN_D])      count_d = count_q + NUM_LEDS'(1);
          else if (press_c[BTN_D] && !press_c[BTN_U]) count_d = count_q - NUM_LEDS'(1);
        end
        SHIFT: begin
          if (press_c[BTN_L] && !press_c[BTN_R])
            rot_d = {rot_q[NUM_LEDS-2:0], rot_q[NUM_LEDS-1]};
          else if (press_c[BTN_R] && !press_c[BTN_L])
            rot_d = {rot_q[0], rot_q[NUM_LEDS-1:1]};
        end
        default: ;
      endcase
    end

    case (mode_d)
      MIRROR:  leds_d = sw_db;
      COUNT:   leds_d = count_d;
      SHIFT:   leds_d = rot_d;
      default: leds_d = '0;
    endcase
  end

  assign io.o_leds = leds_q;
  assign io.o_mode = mode_q;

endmodule

// File: tb/tb_basic_io_led_ctrl.sv
// Directed bench for basic_io_led_ctrl with short debounce (4 cycles).
module tb_basic_io_led_ctrl;
  import basic_io_pkg::*;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;

  localparam logic [5:0] M_C   = 6'b000001;
  localparam logic [5:0] M_U   = 6'b000010;
  localparam logic [5:0] M_D   = 6'b000100;
  localparam logic [5:0] M_L   = 6'b001000;
  localparam logic [5:0] M_R   = 6'b010000;
  localparam logic [5:0] M_CLR = 6'b100000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  basic_io_led_ctrl_if io_if ();

  basic_io_led_ctrl #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (io_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing on a falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a button pattern long enough to debounce, then release and settle
  task automatic press(input logic [5:0] mask);
    io_if.i_buttons = mask;
    step(10);
    io_if.i_buttons = '0;
    step(10);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] leds, input logic [1:0] mode);
    check({tag, "_leds"}, 32'(io_if.o_leds), 32'(leds));
    check({tag, "_mode"}, 32'(io_if.o_mode), 32'(mode));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    io_if.i_buttons  = '0;
    io_if.i_switches = '0;
    step(3);
    rst = 1'b0;
    expect_out("reset", 8'h00, 2'd0);

    // Clean switch step: visible exactly 7 edges later
    io_if.i_switches = 8'hA5;
    step(6);
    check("sw_latency_pre", 32'(io_if.o_leds), 32'h00);
    step(1);
    expect_out("sw_latency", 8'hA5, 2'd0);

    // Short glitch on bit0 must never reach the LEDs
    io_if.i_switches = 8'hA4;
    step(10);
    check("glitch_base", 32'(io_if.o_leds), 32'hA4);
    io_if.i_switches = 8'hA5;
    step(3);
    io_if.i_switches = 8'hA4;
    for (int i = 0; i < 10; i++) begin
      check("glitch_hold", 32'(io_if.o_leds), 32'hA4);
      step(1);
    end

    // COUNT mode: increment and wrap on decrement
    press(M_C);
    expect_out("to_count", 8'h00, 2'd1);
    repeat (3) press(M_U);
    expect_out("up3", 8'h03, 2'd1);
    repeat (4) press(M_D);
    expect_out("down4_wrap", 8'hFF, 2'd1);

    // SHIFT mode loads switches on entry, rotates both ways
    io_if.i_switches = 8'h81;
    step(10);
    check("count_hold_sw", 32'(io_if.o_leds), 32'hFF);
    press(M_C);
    expect_out("to_shift", 8'h81, 2'd2);
    press(M_C);
    expect_out("to_mirror", 8'h81, 2'd0);
    press(M_C);
    expect_out("count_persist", 8'hFF, 2'd1);
    press(M_C);
    expect_out("shift_again", 8'h81, 2'd2);
    press(M_L);
    expect_out("rot_left", 8'h03, 2'd2);
    press(M_R);
    expect_out("rot_right1", 8'h81, 2'd2);
    press(M_R);
    expect_out("rot_right2", 8'hC0, 2'd2);
    press(M_L | M_R);
    expect_out("rot_both", 8'hC0, 2'd2);

    // Simultaneous up/down, wrap-up, clear overriding centre
    press(M_C);
    expect_out("mirror2", 8'h81, 2'd0);
    press(M_C);
    expect_out("count2", 8'hFF, 2'd1);
    press(M_U | M_D);
    expect_out("up_down", 8'hFF, 2'd1);
    press(M_U);
    expect_out("up_wrap", 8'h00, 2'd1);
    press(M_U);
    expect_out("up_one", 8'h01, 2'd1);
    press(M_CLR | M_C);
    expect_out("clr_centre", 8'h00, 2'd1);

    // Clear in SHIFT zeroes the rotate register
    press(M_C);
    expect_out("shift3", 8'h81, 2'd2);
    press(M_CLR);
    expect_out("clr_shift", 8'h00, 2'd2);

    // MIRROR ignores direction buttons
    press(M_C);
    expect_out("mirror3", 8'h81, 2'd0);
    press(M_U | M_L);
    expect_out("mirror_ignore", 8'h81, 2'd0);
    press(M_C);
    press(M_U);
    expect_out("count3", 8'h01, 2'd1);

    // Reset while centre is mid-debounce (counter at 2), button stays held
    io_if.i_buttons = M_C;
    step(4);
    rst = 1'b1;
    step(1);
    expect_out("mid_reset", 8'h00, 2'd0);
    rst = 1'b0;
    step(6);
    check("post_rst_pre", 32'(io_if.o_mode), 32'd0);
    step(1);
    expect_out("post_rst_pulse", 8'h00, 2'd1);
    step(20);
    check("post_rst_single", 32'(io_if.o_mode), 32'd1);
    io_if.i_buttons = '0;
    step(10);
    expect_out("post_rst_release", 8'h00, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/basic_io_led_ctrl.md
Name: basic_io_led_ctrl

Overview:
Board-side RTL for the Nexys Video basic I/O path. It consumes the raw push buttons and slide switches, synchronizes and debounces them, and derives single-cycle press pulses. A three-mode controller drives the LEDs from those pulses. The basic_io agent's monitor observes these pins (i_buttons, i_switches, o_leds).

Parameters:
- SYNC_STAGES, 2, flip-flop synchronizer depth per input bit; minimum 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz); minimum 2; benches use 4.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_buttons  input  6  raw buttons: [0] centre, [1] up, [2] down, [3] left, [4] right, [5] clear.
- i_switches  input  8  raw slide switches.
- o_leds  output  8  registered LED drive.
- o_mode  output  2  current mode: 0 MIRROR, 1 COUNT, 2 SHIFT.

Behaviour:
- Reset (i_rst=1 on a clock edge): all synchronizer flops, debounced values, debounce counters, press-detect history, count_reg, rot_reg and o_leds go to 0; o_mode goes to MIRROR. A mid-operation reset discards any pending debounce; no pulse is emitted for it.
- Synchronizer: each input bit passes through a SYNC_STAGES-deep flop chain.
- Debounce, per bit, with its own counter of width $clog2(DEBOUNCE_CYCLES):
  - If the synchronized value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the value still differs, the debounced value takes the synchronized value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected.
- Press pulse: asserted for one cycle when a debounced button goes 0->1. There is no pulse on release. A button held through reset produces a pulse once debounced after reset.
- Priority among pulses in the same cycle:
  - clear: count_reg=0, rot_reg=0, mode unchanged; overrides every other pulse.
  - else centre: mode advances MIRROR->COUNT->SHIFT->MIRROR. On entry to SHIFT, rot_reg loads the debounced switches. Other pulses in that cycle are ignored.
  - else, in COUNT: up gives count_reg+1, down gives count_reg-1, both give no change. Modulo-256 wrap: 0xFF+1=0x00, 0x00-1=0xFF.
  - else, in SHIFT: left gives rotate-left-by-1 (bit7 to bit0), right gives rotate-right-by-1, both give no change.
  - In MIRROR, up/down/left/right are ignored.
- count_reg and rot_reg persist across mode changes.
- o_leds is registered each cycle from the next-state values: MIRROR gives debounced switches, COUNT gives count_reg, SHIFT gives rot_reg. mode value 3 is unreachable; if it occurs, leds=0 and the next centre pulse goes to MIRROR.
- Latency from a clean input step to o_leds: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles. o_mode updates on the same edge as o_leds.

Decomposition:
- Shared package basic_io_pkg:
  - mode enum (MIRROR/COUNT/SHIFT), 2 bits.
  - button index constants BTN_C, BTN_U, BTN_D, BTN_L, BTN_R, BTN_CLR.
  - NUM_BUTTONS=6, NUM_SWITCHES=8, NUM_LEDS=8.
- Sub-module basic_io_debounce, parameterised by WIDTH, SYNC_STAGES and DEBOUNCE_CYCLES. It contains the synchronizer, the per-bit counters and the debounced output. It is instantiated twice: once for the buttons (WIDTH=6) and once for the switches (WIDTH=8).
- Rising-edge detection, the mode state machine and the LED mux stay in basic_io_led_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset, then i_switches=0xA5 held -> o_leds=0xA5 exactly 7 cycles after the change; o_mode=0.
- Switch bit0 toggles high for 3 cycles, then returns low -> o_leds never changes (glitch rejected).
- Centre press (held 10 cycles) -> o_mode=1 and o_leds=0x00. Then 3 up presses -> 0x03. Then 4 down presses -> 0xFF (wrap).
- With switches=0x81, centre press twice from MIRROR -> o_mode=2 and o_leds=0x81. Then left -> 0x03; right twice -> 0xC0.
- Up and down pressed on the same cycle in COUNT -> count unchanged. Clear and centre together -> count=0, mode unchanged.
- Assert i_rst while a button is mid-debounce (counter=2) -> all outputs 0 and mode MIRROR next cycle. With the button still held, exactly one press pulse follows after re-debounce.
